// File: rtl/mem_wait_ctrl_if.sv
// Pipeline-side request/response and SRAM bus signals of the data-memory controller.
// master = pipeline/SRAM environment, slave = the controller.
interface mem_wait_ctrl_if #(
    parameter int SRAM_AW = 16
);
    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        addr;
    logic [31:0]        wr_data;
    logic [31:0]        rd_data;
    logic               ready;
    logic               freeze;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic               sram_wdata_oe;
    logic [31:0]        sram_rdata;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport master (
        output mem_r_en, mem_w_en, addr, wr_data, sram_rdata,
        input  rd_data, ready, freeze, sram_addr, sram_wdata,
               sram_wdata_oe, sram_we_n, sram_oe_n
    );

    modport slave (
        input  mem_r_en, mem_w_en, addr, wr_data, sram_rdata,
        output rd_data, ready, freeze, sram_addr, sram_wdata,
               sram_wdata_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Fixed-wait-state SRAM controller for the MEM stage. Freezes the pipeline
// while an access is in flight and releases it for the single DONE cycle.
module mem_wait_ctrl #(
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_wait_ctrl_if.slave bus
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          is_wr;
    logic          req;
    logic          cnt_last;

    assign req      = bus.mem_r_en | bus.mem_w_en;
    assign cnt_last = (cnt == CNT_LAST);

    // State register; reset lands in IDLE asynchronously so strobes drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and all handshake/strobe outputs, decoded from the current state.
    // Strobes are also gated by req so a flush releases the bus immediately.
    always_comb begin
        state_nxt         = state;
        bus.freeze        = 1'b0;
        bus.ready         = 1'b0;
        bus.sram_we_n     = 1'b1;
        bus.sram_oe_n     = 1'b1;
        bus.sram_wdata_oe = 1'b0;
        case (state)
            IDLE: begin
                bus.freeze = req;
                if (req) state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.freeze = 1'b1;
                if (!req) begin
                    state_nxt = IDLE;
                end else begin
                    bus.sram_we_n     = ~is_wr;
                    bus.sram_wdata_oe = is_wr;
                    bus.sram_oe_n     = is_wr;
                    if (cnt_last) state_nxt = DONE;
                end
            end
            DONE: begin
                bus.ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access datapath: latch address/data/direction on issue, count wait states,
    // capture read data on the last wait-state edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            is_wr          <= 1'b0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.rd_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt            <= '0;
                        is_wr          <= bus.mem_w_en;
                        bus.sram_addr  <= SRAM_AW'((bus.addr - 32'(BASE_ADDR)) >> 2);
                        bus.sram_wdata <= bus.wr_data;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (req && cnt_last && !is_wr) bus.rd_data <= bus.sram_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule
